// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the write-back stage: FSM state encoding, default
// datapath widths, default load timeout and the hard-wired zero register.
package writeback_stage_pkg;

  localparam int DATA_W_DEF      = 32;
  localparam int REG_ADDR_W_DEF  = 5;
  localparam int MEM_TIMEOUT_DEF = 15;

  // r0 is hard-wired to zero in the register file; writes to it are dropped.
  localparam int ZERO_REG = 0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    COMMIT   = 2'd2
  } wb_state_e;

endpackage

// File: rtl/writeback_stage_mem_wait_timer.sv
// Load wait timer. Counts cycles spent waiting for data memory.
//   clk_i      clock, rising edge
//   rst_n_i    asynchronous active-low reset
//   clr_i      restart count at 0 (wins over enable)
//   en_i       advance count this cycle
//   expired_o  this is the MEM_TIMEOUT-th enabled cycle since the last clear
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)   cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i)  cnt_q <= cnt_q + CW'(1);
  end

  // Count starts at 0 on the first wait cycle, so the MEM_TIMEOUT-th wait
  // cycle sees MEM_TIMEOUT-1. The owner leaves the wait state on that edge.
  assign expired_o = (cnt_q == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/writeback_stage.sv
// Write-back stage: retires one instruction per cycle into the register file.
// ALU results commit the cycle after acceptance; loads wait for MemReady with
// a bounded timeout, after which the write is dropped and Mem_Error pulses.
//   Clk, Reset_n                 clock / async active-low reset
//   In_Valid / In_Ready          retiring-instruction handshake
//   RegWrite, MemtoReg, WriteReg, ALUResult   instruction fields
//   MemReady, MemReadData        load data return
//   RF_WriteEn/Addr/Data         registered register-file write port (also the
//                                forwarding source for the ALU operand muxes)
//   Load_Pending, Pending_Reg    outstanding-load info for the hazard unit
//   Mem_Error                    one-cycle pulse on load timeout
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  In_Valid,
  output logic                  In_Ready,
  input  logic                  RegWrite,
  input  logic                  MemtoReg,
  input  logic [REG_ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0]     ALUResult,
  input  logic                  MemReady,
  input  logic [DATA_W-1:0]     MemReadData,
  output logic                  RF_WriteEn,
  output logic [REG_ADDR_W-1:0] RF_WriteAddr,
  output logic [DATA_W-1:0]     RF_WriteData,
  output logic                  Load_Pending,
  output logic [REG_ADDR_W-1:0] Pending_Reg,
  output logic                  Mem_Error
);

  localparam logic [REG_ADDR_W-1:0] ZREG = REG_ADDR_W'(ZERO_REG);

  wb_state_e             state_q;
  logic                  regwrite_q;
  logic [REG_ADDR_W-1:0] wreg_q;
  logic                  rf_we_q;
  logic [REG_ADDR_W-1:0] rf_addr_q;
  logic [DATA_W-1:0]     rf_data_q;
  logic                  mem_err_q;

  logic accept, waiting, expired;

  assign waiting  = (state_q == WAIT_MEM);
  assign In_Ready = !waiting;
  assign accept   = In_Valid && In_Ready;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk_i     (Clk),
    .rst_n_i   (Reset_n),
    .clr_i     (accept && MemtoReg),
    .en_i      (waiting && !MemReady),
    .expired_o (expired)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_data_q  <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      rf_we_q   <= 1'b0;
      mem_err_q <= 1'b0;
      case (state_q)
        WAIT_MEM: begin
          // MemReady takes priority over an expiring timer.
          if (MemReady) begin
            rf_we_q   <= regwrite_q && (wreg_q != ZREG);
            rf_addr_q <= wreg_q;
            rf_data_q <= MemReadData;
            state_q   <= COMMIT;
          end else if (expired) begin
            mem_err_q <= 1'b1;
            state_q   <= COMMIT;
          end
        end
        default: begin
          // IDLE and COMMIT both accept; MemReady is ignored here.
          if (accept) begin
            regwrite_q <= RegWrite;
            wreg_q     <= WriteReg;
            if (MemtoReg) begin
              state_q <= WAIT_MEM;
            end else begin
              rf_we_q   <= RegWrite && (WriteReg != ZREG);
              rf_addr_q <= WriteReg;
              rf_data_q <= ALUResult;
              state_q   <= COMMIT;
            end
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign RF_WriteEn   = rf_we_q;
  assign RF_WriteAddr = rf_addr_q;
  assign RF_WriteData = rf_data_q;
  assign Mem_Error    = mem_err_q;
  assign Load_Pending = waiting;
  assign Pending_Reg  = waiting ? wreg_q : ZREG;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        In_Valid, In_Ready, RegWrite, MemtoReg, MemReady;
  logic [4:0]  WriteReg, RF_WriteAddr, Pending_Reg;
  logic [31:0] ALUResult, MemReadData, RF_WriteData;
  logic        RF_WriteEn, Load_Pending, Mem_Error;

  int tests = 0;
  int fails = 0;

  writeback_stage dut (
    .Clk(Clk), .Reset_n(Reset_n), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .WriteReg(WriteReg),
    .ALUResult(ALUResult), .MemReady(MemReady), .MemReadData(MemReadData),
    .RF_WriteEn(RF_WriteEn), .RF_WriteAddr(RF_WriteAddr),
    .RF_WriteData(RF_WriteData), .Load_Pending(Load_Pending),
    .Pending_Reg(Pending_Reg), .Mem_Error(Mem_Error)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r,
                       input logic [4:0] wr, input logic [31:0] alu);
    In_Valid = v; RegWrite = rw; MemtoReg = m2r; WriteReg = wr; ALUResult = alu;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [4:0] a,
                        input logic [31:0] d);
    chk({tag, ".we"}, RF_WriteEn, we);
    chk({tag, ".addr"}, RF_WriteAddr, a);
    chk({tag, ".data"}, RF_WriteData, d);
  endtask

  initial begin
    Reset_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    MemReady = 0; MemReadData = 0;
    #22;
    chk_wr("rst", 0, 0, 0);
    chk("rst.err", Mem_Error, 0);
    chk("rst.pend", Load_Pending, 0);
    chk("rst.preg", Pending_Reg, 0);
    chk("rst.rdy", In_Ready, 1);
    Reset_n = 1'b1;

    // ALU ops, back-to-back
    drive(1, 1, 0, 8, 32'h0000_1234); tick();
    chk_wr("alu1", 1, 8, 32'h0000_1234);
    chk("alu1.rdy", In_Ready, 1);
    drive(1, 1, 0, 10, 32'hA5A5_5A5A); tick();
    chk_wr("alu2", 1, 10, 32'hA5A5_5A5A);
    drive(0, 0, 0, 0, 0); tick();
    chk("alu.idle.we", RF_WriteEn, 0);

    // r0 target and RegWrite=0 never strobe, but addr/data follow
    drive(1, 1, 0, 0, 32'hFFFF_FFFF); tick();
    chk_wr("r0", 0, 0, 32'hFFFF_FFFF);
    drive(1, 0, 0, 5, 32'h0000_0055); tick();
    chk_wr("norw", 0, 5, 32'h0000_0055);
    drive(0, 0, 0, 0, 0); tick();

    // Stray MemReady while idle is ignored
    MemReady = 1; MemReadData = 32'h0000_0BAD; tick();
    chk_wr("stray", 0, 5, 32'h0000_0055);
    chk("stray.pend", Load_Pending, 0);
    MemReady = 0;

    // Load to r9, MemReady after 3 wait cycles; new input held off meanwhile
    drive(1, 1, 1, 9, 0); tick();
    chk("ld.pend", Load_Pending, 1);
    chk("ld.preg", Pending_Reg, 9);
    chk("ld.rdy", In_Ready, 0);
    drive(1, 1, 0, 12, 32'h0000_0C0C); tick();
    chk("ld.blk.we", RF_WriteEn, 0);
    chk("ld.blk.rdy", In_Ready, 0);
    chk("ld.blk.preg", Pending_Reg, 9);
    drive(0, 0, 0, 0, 0); tick();
    chk("ld.w3.pend", Load_Pending, 1);
    MemReady = 1; MemReadData = 32'hDEAD_BEEF; tick();
    chk_wr("ld.done", 1, 9, 32'hDEAD_BEEF);
    chk("ld.done.pend", Load_Pending, 0);
    chk("ld.done.preg", Pending_Reg, 0);
    chk("ld.done.err", Mem_Error, 0);
    MemReady = 0; tick();
    chk("ld.after.we", RF_WriteEn, 0);

    // Timeout: 15 wait cycles with no MemReady
    drive(1, 1, 1, 11, 0); tick();
    drive(0, 0, 0, 0, 0);
    for (int i = 1; i < 15; i++) begin
      tick();
      chk($sformatf("to.w%0d.pend", i), Load_Pending, 1);
      chk($sformatf("to.w%0d.err", i), Mem_Error, 0);
    end
    tick();
    chk("to.err", Mem_Error, 1);
    chk("to.we", RF_WriteEn, 0);
    chk("to.rdy", In_Ready, 1);
    chk("to.pend", Load_Pending, 0);
    tick();
    chk("to.err.pulse", Mem_Error, 0);

    // MemReady on the expiring cycle wins
    drive(1, 1, 1, 13, 0); tick();
    drive(0, 0, 0, 0, 0);
    for (int i = 1; i < 15; i++) tick();
    chk("co.pend", Load_Pending, 1);
    MemReady = 1; MemReadData = 32'h1357_9BDF; tick();
    chk_wr("co", 1, 13, 32'h1357_9BDF);
    chk("co.err", Mem_Error, 0);
    MemReady = 0; tick();
    chk("co.after.err", Mem_Error, 0);

    // MemReady already high at accept: minimum latency of 2
    MemReady = 1; MemReadData = 32'h0000_00E1;
    drive(1, 1, 1, 14, 0); tick();
    drive(0, 0, 0, 0, 0);
    chk("min.w1.we", RF_WriteEn, 0);
    chk("min.w1.pend", Load_Pending, 1);
    tick();
    chk_wr("min", 1, 14, 32'h0000_00E1);
    MemReady = 0; tick();

    // Reset during WAIT_MEM drops the load
    drive(1, 1, 1, 15, 0); tick();
    drive(0, 0, 0, 0, 0); tick();
    chk("rml.pend", Load_Pending, 1);
    Reset_n = 0; #1;
    chk_wr("rml.rst", 0, 0, 0);
    chk("rml.pend0", Load_Pending, 0);
    chk("rml.preg0", Pending_Reg, 0);
    MemReady = 1; MemReadData = 32'h7777_7777; tick();
    chk("rml.we", RF_WriteEn, 0);
    Reset_n = 1; tick();
    chk_wr("rml.post", 0, 0, 0);
    chk("rml.post.pend", Load_Pending, 0);
    MemReady = 0;
    drive(1, 1, 0, 3, 32'h0000_0303); tick();
    chk_wr("rml.alu", 1, 3, 32'h0000_0303);
    drive(0, 0, 0, 0, 0); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: timeout reached, expected bench completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Write-back stage of the 32-bit MIPS datapath: the return path of the ALU operand path, carrying results from the EX/MEM boundary back into the register file. Accepts one retiring instruction per cycle, selects ALU result or load data (MemtoReg), waits on data memory for loads with a bounded timeout, and drives the register-file write port. The same registered result is exported as a forwarding source for the ALU operand muxes.

## Interface
- DATA_W, 32, datapath width
- REG_ADDR_W, 5, register address width
- MEM_TIMEOUT, 15, max cycles spent waiting for MemReady before abort (1..255)

- Clk  in  1  clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- In_Valid  in  1  retiring instruction present
- In_Ready  out  1  stage can accept this cycle
- RegWrite  in  1  instruction writes a register
- MemtoReg  in  1  1 = load (data from memory), 0 = ALU result
- WriteReg  in  REG_ADDR_W  destination register
- ALUResult  in  DATA_W  ALU result
- MemReady  in  1  MemReadData valid this cycle
- MemReadData  in  DATA_W  load data
- RF_WriteEn  out  1  register-file write strobe
- RF_WriteAddr  out  REG_ADDR_W  write address
- RF_WriteData  out  DATA_W  write data
- Load_Pending  out  1  load outstanding (hazard unit stalls dependents)
- Pending_Reg  out  REG_ADDR_W  destination of outstanding load
- Mem_Error  out  1  one-cycle pulse on load timeout

## Operation
- States: IDLE, WAIT_MEM, COMMIT. Reset → IDLE.
- Accept = In_Valid && In_Ready. In_Ready = (state != WAIT_MEM).
- On accept, capture RegWrite, WriteReg. MemtoReg=0: capture ALUResult, → COMMIT. MemtoReg=1: → WAIT_MEM, clear wait counter.
- No accept in IDLE/COMMIT → IDLE.
- WAIT_MEM: MemReady=1 → capture MemReadData, → COMMIT. Else counter increments; counter reaching MEM_TIMEOUT with no MemReady → COMMIT with write suppressed, Mem_Error pulses that cycle.
- MemReady sampled only in WAIT_MEM; ignored elsewhere.
- COMMIT: RF_WriteEn = captured RegWrite && captured WriteReg != 0 && !aborted. In_Ready=1; back-to-back accept selects next state from the new instruction.
- Writes to register 0 never strobe RF_WriteEn; RF_WriteAddr/Data still update.
- Load_Pending = (state == WAIT_MEM); Pending_Reg = captured WriteReg, 0 when not pending.
- RF_WriteEn/Addr/Data, Mem_Error are registered outputs.

## Timing
- ALU op accepted at edge N → RF_WriteEn high cycle N+1, exactly one cycle.
- Load accepted at edge N → WAIT_MEM from N+1; MemReady high in cycle M (M ≥ N+1) → RF_WriteEn in cycle M+1. Minimum load latency 2 cycles.
- Timeout: MEM_TIMEOUT cycles in WAIT_MEM without MemReady → Mem_Error high one cycle, RF_WriteEn stays 0, next cycle In_Ready=1.
- MemReady on the same cycle the counter expires: MemReady wins, no error.
- Throughput: one ALU instruction per cycle; a load blocks acceptance until completion/abort.
- Reset (any cycle, incl. mid-load): state IDLE, counter 0, all outputs 0, pending load dropped, no write. First accept possible on first edge after Reset_n deasserts.

## Structure
- Shared package: state enum (IDLE, WAIT_MEM, COMMIT), DATA_W/REG_ADDR_W defaults, zero-register constant.
- One sub-module: mem_wait_timer (clear, enable, expired at MEM_TIMEOUT; async active-low reset).

## Test plan
- ALU op: RegWrite=1, MemtoReg=0, WriteReg=8, ALUResult=0x0000_1234 → next cycle RF_WriteEn=1, addr 8, data 0x1234; back-to-back ops write every cycle.
- Load: WriteReg=9, MemtoReg=1, MemReady after 3 cycles with 0xDEAD_BEEF → Load_Pending=1/Pending_Reg=9 meanwhile, In_Ready=0, write of 0xDEADBEEF to r9 the cycle after MemReady.
- Timeout: load, MemReady held 0 → Mem_Error pulse after 15 WAIT_MEM cycles, no RF write, In_Ready returns 1.
- Register 0: ALU op to r0 with 0xFFFF_FFFF → RF_WriteEn stays 0; RegWrite=0 to r5 → no write.
- Reset mid-load: assert Reset_n=0 in WAIT_MEM, then MemReady → all outputs 0, no write, state IDLE.
- Stray MemReady in IDLE/COMMIT and MemReady coincident with expiry → ignored / load completes without Mem_Error.
